// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the LCD scene scheduler.
//   state_t          : scheduler state (MONITOR shows the patient view,
//                      MISSED shows one missed-dose entry)
//   SCENE_MONITOR /
//   SCENE_MISSED     : scene_sel encodings expected by the frame sequencer
//   dwell_cnt_width  : width of a counter that must reach DWELL_TICKS
// Optional feature macro: LCD_SCHED_RR_EN (see rr_pick).
package lcd_sched_pkg;

  typedef enum logic {
    MONITOR = 1'b0,
    MISSED  = 1'b1
  } state_t;

  localparam logic SCENE_MONITOR = 1'b1;
  localparam logic SCENE_MISSED  = 1'b0;

  // Enough bits to hold the value DWELL_TICKS itself (saturation point).
  function automatic int dwell_cnt_width(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/lcd_scene_scheduler_rr_pick.sv
// rr_pick: combinational finder for the next missed entry to display.
// Ports:
//   mask    in  NUM_ENTRIES  candidate entries (bit i = entry i pending)
//   pointer in  ADDR_W       entry shown last (search starts after it)
//   index   out ADDR_W       chosen entry (0 when none)
//   valid   out 1            at least one bit of mask is set
// Macro LCD_SCHED_RR_EN:
//   defined   -> round-robin: first set bit after pointer, wrapping; if the
//                only set bit equals pointer, that entry is chosen again.
//   undefined -> fixed priority: lowest-index set bit; pointer is ignored.
module rr_pick
  import lcd_sched_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 3
) (
  input  logic [NUM_ENTRIES-1:0] mask,
  input  logic [ADDR_W-1:0]      pointer,
  output logic [ADDR_W-1:0]      index,
  output logic                   valid
);

`ifndef LCD_SCHED_RR_EN
  logic unused_pointer;
  assign unused_pointer = ^pointer;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    index = '0;
    valid = 1'b0;
`ifdef LCD_SCHED_RR_EN
    // Offsets 1..NUM_ENTRIES; the last offset lands back on pointer itself.
    for (int k = 1; k <= NUM_ENTRIES; k++) begin
      if (!valid && mask[(int'(pointer) + k) % NUM_ENTRIES]) begin
        valid = 1'b1;
        index = ADDR_W'((int'(pointer) + k) % NUM_ENTRIES);
      end
    end
`else
    // Scan high to low so the lowest set bit is the last one written.
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (mask[k]) begin
        valid = 1'b1;
        index = ADDR_W'(k);
      end
    end
`endif
  end

endmodule

// File: rtl/lcd_scene_scheduler.sv
// lcd_scene_scheduler: chooses what the LCD frame sequencer paints next,
// either the patient monitor view or one missed-dose entry, and forwards
// user acknowledgements to the missed-dose tracker.
// Ports:
//   CLK_400Hz    in  1            system clock
//   reset        in  1            synchronous, active-high reset
//   frame_done   in  1            pulse after the last character of a frame
//   monitor_addr in  ADDR_W       current schedule entry from time-keeping
//   missed_mask  in  NUM_ENTRIES  bit i = entry i missed, not yet acked
//   ack_btn      in  1            debounced one-cycle acknowledge pulse
//   scene_sel    out 1            1 = monitor scene, 0 = missed scene
//   rom_addr     out ADDR_W       schedule entry to display
//   missed_ack   out NUM_ENTRIES  one-hot one-cycle clear to the tracker
//   in_missed    out 1            high while a missed entry is displayed
// scene_sel and rom_addr only move on the edge that samples frame_done, so
// a frame never mixes two entries. ADDR_W must satisfy 2**ADDR_W >= NUM_ENTRIES.
// Macro LCD_SCHED_RR_EN selects round-robin picking (builds the rr pointer);
// without it the lowest pending entry is always shown.
module lcd_scene_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int DWELL_TICKS = 800,
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 3
) (
  input  logic                   CLK_400Hz,
  input  logic                   reset,
  input  logic                   frame_done,
  input  logic [ADDR_W-1:0]      monitor_addr,
  input  logic [NUM_ENTRIES-1:0] missed_mask,
  input  logic                   ack_btn,
  output logic                   scene_sel,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [NUM_ENTRIES-1:0] missed_ack,
  output logic                   in_missed
);

  localparam int DW = dwell_cnt_width(DWELL_TICKS);

  state_t                 state_q, state_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic [ADDR_W-1:0]      cur_q, cur_d;
  logic                   ack_taken_q, ack_taken_d;
  logic                   scene_sel_d;
  logic [ADDR_W-1:0]      rom_addr_d;
  logic [NUM_ENTRIES-1:0] missed_ack_d;

  logic                   expired;
  logic                   ack_hit;
  logic [ADDR_W-1:0]      pick_idx;
  logic                   pick_valid;
  logic [ADDR_W-1:0]      pick_ptr;

`ifdef LCD_SCHED_RR_EN
  logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
  assign pick_ptr = rr_ptr_q;
`else
  assign pick_ptr = '1;
`endif

  rr_pick #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .ADDR_W     (ADDR_W)
  ) u_pick (
    .mask   (missed_mask),
    .pointer(pick_ptr),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

  assign expired   = (dwell_q == DW'(DWELL_TICKS));
  assign in_missed = (state_q == MISSED);
  // Only one acknowledge per missed scene, and only for a still-pending entry.
  assign ack_hit   = (state_q == MISSED) && ack_btn && missed_mask[cur_q] && !ack_taken_q;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    ack_taken_d  = ack_taken_q;
    scene_sel_d  = scene_sel;
    rom_addr_d   = rom_addr;
    missed_ack_d = '0;
    dwell_d      = expired ? dwell_q : dwell_q + DW'(1);
`ifdef LCD_SCHED_RR_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    case (state_q)
      MONITOR: begin
        if (frame_done) begin
          rom_addr_d = monitor_addr;
          if (expired && pick_valid) begin
            state_d     = MISSED;
            cur_d       = pick_idx;
            rom_addr_d  = pick_idx;
            scene_sel_d = SCENE_MISSED;
            ack_taken_d = 1'b0;
            dwell_d     = '0;
`ifdef LCD_SCHED_RR_EN
            rr_ptr_d    = pick_idx;
`endif
          end
        end
      end
      MISSED: begin
        if (ack_hit) begin
          missed_ack_d[cur_q] = 1'b1;
          ack_taken_d         = 1'b1;
        end
        if (frame_done) begin
          // ack_hit covers an acknowledge arriving on the frame_done edge.
          if (expired || !missed_mask[cur_q] || ack_taken_q || ack_hit) begin
            state_d     = MONITOR;
            rom_addr_d  = monitor_addr;
            scene_sel_d = SCENE_MONITOR;
            dwell_d     = '0;
          end else begin
            rom_addr_d = cur_q;
          end
        end
      end
    endcase
  end

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK_400Hz) begin
    if (reset) begin
      state_q     <= MONITOR;
      dwell_q     <= '0;
      cur_q       <= '0;
      ack_taken_q <= 1'b0;
      scene_sel   <= SCENE_MONITOR;
      rom_addr    <= '0;
      missed_ack  <= '0;
`ifdef LCD_SCHED_RR_EN
      rr_ptr_q    <= ADDR_W'(NUM_ENTRIES - 1);
`endif
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      cur_q       <= cur_d;
      ack_taken_q <= ack_taken_d;
      scene_sel   <= scene_sel_d;
      rom_addr    <= rom_addr_d;
      missed_ack  <= missed_ack_d;
`ifdef LCD_SCHED_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule
